alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 35 +++
 rtl/alu_arbiter_rr_pick.sv | 20 ++
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: op codes, buffer states and
// the branch-op predicate used to steer result vs. compare-flag capture.
package alu_arbiter_pkg;

  localparam int N_REQ = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13,
    OP_BLTU = 4'd14,
    OP_BGEU = 4'd15
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op >= OP_BEQ);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Two-way round-robin pick: ptr names the preferred requester when both are
// valid; a lone valid requester always wins.
module alu_rr_pick
  import alu_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic             ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (enable) begin
      if (valid == 2'b11) gnt[ptr] = 1'b1;
      else                gnt      = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, capturing each
// granted operation's result into a one-entry response buffer.
//
//   state    | meaning
//   ST_EMPTY | response buffer free, a grant may be issued
//   ST_FULL  | rsp_valid=1; a grant may refill only if rsp_ready drains it
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][3:0]        req_op,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_in1,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_in2,
  output logic [N_REQ-1:0]             req_ready,
  output logic [3:0]                   alu_ctrl,
  output logic [DATA_W-1:0]            alu_in1,
  output logic [DATA_W-1:0]            alu_in2,
  input  logic [DATA_W-1:0]            alu_out,
  input  logic                         alu_zero,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_id,
  output logic [DATA_W-1:0]            rsp_out,
  output logic                         rsp_zero,
  output logic [CNT_W-1:0]             gnt_cnt0,
  output logic [CNT_W-1:0]             gnt_cnt1
);

  buf_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              grant_en;
  logic [N_REQ-1:0]  gnt;
  logic              granted;
  logic              gnt_idx;

  // rst_n gates the enable so req_ready is 0 for the whole reset window
  assign grant_en = rst_n && ((state_q == ST_EMPTY) || rsp_ready);

  alu_rr_pick u_pick (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .enable (grant_en),
    .gnt    (gnt)
  );

  assign granted = |gnt;
  assign gnt_idx = gnt[1];

  always_comb begin
    alu_ctrl = '0;
    alu_in1  = '0;
    alu_in2  = '0;
    if (granted) begin
      alu_ctrl = req_op[gnt_idx];
      alu_in1  = req_in1[gnt_idx];
      alu_in2  = req_in2[gnt_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_out_d  = rsp_out_q;
    rsp_zero_d = rsp_zero_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (granted) begin
      state_d  = ST_FULL;
      ptr_d    = ~gnt_idx;
      rsp_id_d = gnt_idx;
      if (is_branch_op(alu_ctrl)) begin
        rsp_out_d  = '0;
        rsp_zero_d = alu_zero;
      end else begin
        rsp_out_d  = alu_out;
        rsp_zero_d = 1'b0;
      end
      if (gnt[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
      if (gnt[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_out_q  <= rsp_out_d;
      rsp_zero_q <= rsp_zero_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             req_valid = '0;
  logic [1:0][3:0]        req_op    = '0;
  logic [1:0][DATA_W-1:0] req_in1   = '0;
  logic [1:0][DATA_W-1:0] req_in2   = '0;
  logic [1:0]             req_ready;
  logic [3:0]             alu_ctrl;
  logic [DATA_W-1:0]      alu_in1, alu_in2, alu_out;
  logic                   alu_zero;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic                   rsp_id;
  logic [DATA_W-1:0]      rsp_out;
  logic                   rsp_zero;
  logic [CNT_W-1:0]       gnt_cnt0, gnt_cnt1;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .req_ready(req_ready),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // ALU model: branches also produce a difference and non-branches raise the
  // flag, so any leak of the wrong field into the buffer is visible.
  always_comb begin
    alu_out  = alu_in1 - alu_in2;
    alu_zero = 1'b1;
    case (alu_ctrl)
      4'd0:  alu_out = alu_in1 + alu_in2;
      4'd1:  alu_out = alu_in1 - alu_in2;
      4'd2:  alu_out = alu_in1 << alu_in2[4:0];
      4'd3:  alu_out = DATA_W'($signed(alu_in1) < $signed(alu_in2));
      4'd4:  alu_out = DATA_W'(alu_in1 < alu_in2);
      4'd5:  alu_out = alu_in1 ^ alu_in2;
      4'd6:  alu_out = alu_in1 >> alu_in2[4:0];
      4'd7:  alu_out = $signed(alu_in1) >>> alu_in2[4:0];
      4'd8:  alu_out = alu_in1 | alu_in2;
      4'd9:  alu_out = alu_in1 & alu_in2;
      4'd10: alu_zero = (alu_in1 == alu_in2);
      4'd11: alu_zero = (alu_in1 != alu_in2);
      4'd12: alu_zero = ($signed(alu_in1) < $signed(alu_in2));
      4'd13: alu_zero = ($signed(alu_in1) >= $signed(alu_in2));
      4'd14: alu_zero = (alu_in1 < alu_in2);
      default: alu_zero = (alu_in1 >= alu_in2);
    endcase
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int idx, input logic [3:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_op[idx]  = op;
    req_in1[idx] = a;
    req_in2[idx] = b;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
    total++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%h/%h exp=0/0", gnt_cnt0, gnt_cnt1); end
    total++; if (rsp_out !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin bad++; $display("FAIL rst_rsp got out=%h id=%b z=%b exp=0", rsp_out, rsp_id, rsp_zero); end
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_req(0, 4'd0, 32'd5, 32'd3);
    set_req(1, 4'd1, 32'd9, 32'd4);
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL basic_gnt0 got=%b exp=01", req_ready); end
    total++; if (alu_ctrl !== 4'd0 || alu_in1 !== 32'd5 || alu_in2 !== 32'd3) begin bad++; $display("FAIL basic_alu0 got=%h,%h,%h exp=0,5,3", alu_ctrl, alu_in1, alu_in2); end
    step();
    req_valid = 2'b10;
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 32'd8 || rsp_zero !== 1'b0) begin bad++; $display("FAIL basic_rsp0 got v=%b id=%b out=%h z=%b exp=1,0,8,0", rsp_valid, rsp_id, rsp_out, rsp_zero); end
    total++; if (req_ready !== 2'b10 || alu_ctrl !== 4'd1) begin bad++; $display("FAIL basic_gnt1 got=%b ctrl=%h exp=10 ctrl=1", req_ready, alu_ctrl); end
    step();
    req_valid = 2'b00;
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== 32'd5) begin bad++; $display("FAIL basic_rsp1 got v=%b id=%b out=%h exp=1,1,5", rsp_valid, rsp_id, rsp_out); end
    total++; if (req_ready !== 2'b00 || alu_ctrl !== 4'd0 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin bad++; $display("FAIL basic_idle_alu got rdy=%b %h,%h,%h exp=00,0,0,0", req_ready, alu_ctrl, alu_in1, alu_in2); end
    step();
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", rsp_valid); end
    total++; if (gnt_cnt0 !== 16'd1 || gnt_cnt1 !== 16'd1) begin bad++; $display("FAIL basic_cnt got=%0d/%0d exp=1/1", gnt_cnt0, gnt_cnt1); end
  endtask

  task automatic test_branch();
    set_req(0, 4'd14, 32'd1, 32'hFFFF_FFFF);
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL br_gnt got=%b exp=01", req_ready); end
    step();
    set_req(1, 4'd9, 32'h0000_F0F0, 32'h0000_FF00);
    req_valid = 2'b10;
    #1;
    total++; if (rsp_zero !== 1'b1 || rsp_out !== 32'd0 || rsp_id !== 1'b0) begin bad++; $display("FAIL br_bltu got z=%b out=%h id=%b exp=1,0,0", rsp_zero, rsp_out, rsp_id); end
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL br_refill got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    total++; if (rsp_zero !== 1'b0 || rsp_out !== 32'h0000_F000 || rsp_id !== 1'b1) begin bad++; $display("FAIL br_and got z=%b out=%h id=%b exp=0,f000,1", rsp_zero, rsp_out, rsp_id); end
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(0, 4'd0, 32'd1, 32'd2);
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_gnt0 got=%b exp=01", req_ready); end
    step();
    set_req(1, 4'd5, 32'h0000_00FF, 32'h0000_000F);
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req_ready !== 2'b00 || alu_ctrl !== 4'd0) begin bad++; $display("FAIL bp_stall%0d got rdy=%b ctrl=%h exp=00,0", i, req_ready, alu_ctrl); end
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 32'd3 || rsp_zero !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got v=%b id=%b out=%h z=%b exp=1,0,3,0", i, rsp_valid, rsp_id, rsp_out, rsp_zero); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b10 || alu_ctrl !== 4'd5) begin bad++; $display("FAIL bp_release got rdy=%b ctrl=%h exp=10,5", req_ready, alu_ctrl); end
    step();
    req_valid = 2'b00;
    #1;
    total++; if (rsp_id !== 1'b1 || rsp_out !== 32'h0000_00F0) begin bad++; $display("FAIL bp_rsp1 got id=%b out=%h exp=1,f0", rsp_id, rsp_out); end
    step();
  endtask

  task automatic test_alternate();
    logic exp_ptr;
    logic prev;
    exp_ptr = 1'b0;
    prev    = 1'b0;
    set_req(0, 4'd0, 32'd7, 32'd1);
    set_req(1, 4'd1, 32'd7, 32'd1);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (req_ready !== (exp_ptr ? 2'b10 : 2'b01)) begin bad++; $display("FAIL alt_gnt%0d got=%b exp_ptr=%b", i, req_ready, exp_ptr); end
      if (i > 0) begin
        total++; if (rsp_id !== prev || rsp_out !== (prev ? 32'd6 : 32'd8)) begin bad++; $display("FAIL alt_rsp%0d got id=%b out=%0d exp id=%b", i, rsp_id, rsp_out, prev); end
      end
      prev    = exp_ptr;
      exp_ptr = ~exp_ptr;
      step();
    end
    req_valid = 2'b00;
    #1;
    total++; if (gnt_cnt0 !== 16'd8 || gnt_cnt1 !== 16'd8) begin bad++; $display("FAIL alt_cnt got=%0d/%0d exp=8/8", gnt_cnt0, gnt_cnt1); end
    step();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_req(0, 4'd0, 32'd2, 32'd2);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_full got=%b exp=1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_out !== 32'd0 || rsp_id !== 1'b0) begin bad++; $display("FAIL rm_async got v=%b out=%h id=%b exp=0,0,0", rsp_valid, rsp_out, rsp_id); end
    total++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0 || req_ready !== 2'b00) begin bad++; $display("FAIL rm_cnt got=%0d/%0d rdy=%b exp=0/0,00", gnt_cnt0, gnt_cnt1, req_ready); end
    @(negedge clk);
    req_valid = 2'b00; rsp_ready = 1'b1;
    rst_n = 1'b1;
    step();
    step();
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_noresp got=%b exp=0", rsp_valid); end
    set_req(0, 4'd0, 32'd1, 32'd1);
    set_req(1, 4'd1, 32'd5, 32'd1);
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_ptr got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    total++; if (rsp_id !== 1'b0 || rsp_out !== 32'd2) begin bad++; $display("FAIL rm_rsp got id=%b out=%0d exp=0,2", rsp_id, rsp_out); end
    step();
  endtask

  task automatic test_saturate();
    set_req(0, 4'd0, 32'd0, 32'd0);
    req_valid = 2'b01; rsp_ready = 1'b1;
    repeat (65533) step();
    #1;
    total++; if (gnt_cnt0 !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", gnt_cnt0); end
    repeat (4) step();
    #1;
    total++; if (gnt_cnt0 !== 16'hFFFF || gnt_cnt1 !== 16'd0) begin bad++; $display("FAIL sat_cnt got=%h/%h exp=ffff/0", gnt_cnt0, gnt_cnt1); end
    req_valid = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_backpressure();
    test_alternate();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
